// File: rtl/ldpc_enc_sched.sv
// QC-LDPC encoder sequencer: walks the generator table row by row, takes one message
// block per row and issues each row's circulant shifts to the rotate/XOR accumulator.
module ldpc_enc_sched #(
    parameter int unsigned ROWS   = 16,
    parameter int unsigned SHIFTS = 3,
    parameter int unsigned SW     = 9,
    parameter int unsigned CIRC   = 511,
    localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned IW    = (SHIFTS > 1) ? $clog2(SHIFTS) : 1,
    localparam int unsigned GW    = SHIFTS * SW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [GW-1:0] g_row,
    output logic [RW-1:0] row_sel,
    input  logic          msg_valid,
    output logic          msg_ready,
    output logic [SW-1:0] shift_val,
    output logic [IW-1:0] shift_idx,
    output logic          acc_en,
    output logic          acc_clr,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [RW-1:0] RowLast = RW'(ROWS - 1);
    localparam logic [IW-1:0] IdxLast = IW'(SHIFTS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWaitMsg,
        StIssue,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [GW-1:0] word_q, word_d;
    logic          err_q, err_d;
    logic          msg_ready_q, msg_ready_d;
    logic [SW-1:0] shift_val_q, shift_val_d;
    logic [IW-1:0] shift_idx_q, shift_idx_d;
    logic          acc_en_q, acc_en_d;
    logic          acc_clr_q, acc_clr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Row word with out-of-range shifts forced to 0; field 0 sits in the top bits.
    logic [GW-1:0] g_clean;
    logic          g_bad;

    always_comb begin
        g_clean = '0;
        g_bad   = 1'b0;
        for (int i = 0; i < int'(SHIFTS); i++) begin
            if (32'(g_row[(int'(SHIFTS) - 1 - i) * int'(SW) +: SW]) < CIRC) begin
                g_clean[(int'(SHIFTS) - 1 - i) * int'(SW) +: SW] =
                    g_row[(int'(SHIFTS) - 1 - i) * int'(SW) +: SW];
            end else begin
                g_bad = 1'b1;
            end
        end
    end

    function automatic logic [SW-1:0] field_of(input logic [GW-1:0] w, input logic [IW-1:0] k);
        logic [SW-1:0] f;
        f = '0;
        for (int i = 0; i < int'(SHIFTS); i++) begin
            if (k == IW'(i)) begin
                f = w[(int'(SHIFTS) - 1 - i) * int'(SW) +: SW];
            end
        end
        return f;
    endfunction

    // Outputs are computed for the next cycle and registered alongside the state.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        word_d      = word_q;
        err_d       = err_q;
        msg_ready_d = 1'b0;
        shift_val_d = '0;
        shift_idx_d = '0;
        acc_en_d    = 1'b0;
        acc_clr_d   = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d   = StLoad;
                    row_d     = '0;
                    err_d     = 1'b0;
                    acc_clr_d = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            StLoad: begin
                state_d     = StWaitMsg;
                msg_ready_d = 1'b1;
                busy_d      = 1'b1;
            end
            StWaitMsg: begin
                busy_d = 1'b1;
                if (msg_valid && msg_ready_q) begin
                    state_d     = StIssue;
                    word_d      = g_clean;
                    err_d       = err_q | g_bad;
                    acc_en_d    = 1'b1;
                    shift_idx_d = '0;
                    shift_val_d = field_of(g_clean, '0);
                end else begin
                    msg_ready_d = 1'b1;
                end
            end
            StIssue: begin
                if (shift_idx_q == IdxLast) begin
                    if (row_q == RowLast) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StLoad;
                        row_d   = row_q + 1'b1;
                        busy_d  = 1'b1;
                    end
                end else begin
                    busy_d      = 1'b1;
                    acc_en_d    = 1'b1;
                    shift_idx_d = shift_idx_q + 1'b1;
                    shift_val_d = field_of(word_q, shift_idx_q + 1'b1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort beats any handshake or issue step: nothing from this cycle is committed.
        if (abort && (state_q != StIdle)) begin
            state_d     = StIdle;
            row_d       = row_q;
            word_d      = word_q;
            err_d       = err_q;
            msg_ready_d = 1'b0;
            shift_val_d = '0;
            shift_idx_d = '0;
            acc_en_d    = 1'b0;
            acc_clr_d   = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            row_q       <= '0;
            word_q      <= '0;
            err_q       <= 1'b0;
            msg_ready_q <= 1'b0;
            shift_val_q <= '0;
            shift_idx_q <= '0;
            acc_en_q    <= 1'b0;
            acc_clr_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            word_q      <= word_d;
            err_q       <= err_d;
            msg_ready_q <= msg_ready_d;
            shift_val_q <= shift_val_d;
            shift_idx_q <= shift_idx_d;
            acc_en_q    <= acc_en_d;
            acc_clr_q   <= acc_clr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign row_sel   = row_q;
    assign msg_ready = msg_ready_q;
    assign shift_val = shift_val_q;
    assign shift_idx = shift_idx_q;
    assign acc_en    = acc_en_q;
    assign acc_clr   = acc_clr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

    row_in_range: assert property (@(posedge clk) row_q <= RowLast);
    no_ready_while_issuing: assert property (@(posedge clk) !(acc_en_q && msg_ready_q));

endmodule

// File: tb/tb_ldpc_enc_sched.sv
// Randomised bench for ldpc_enc_sched; expected waveforms come from per-row cycle
// arithmetic (load, handshake, issue windows) derived from the stall pattern.
module tb_ldpc_enc_sched;

    localparam int ROWS   = 16;
    localparam int SHIFTS = 3;
    localparam int CIRC   = 511;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        msg_valid = 1'b0;
    logic [26:0] g_row = '0;
    logic [3:0]  row_sel;
    logic        msg_ready;
    logic [8:0]  shift_val;
    logic [1:0]  shift_idx;
    logic        acc_en, acc_clr, busy, done, err;

    ldpc_enc_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .g_row     (g_row),
        .row_sel   (row_sel),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .shift_val (shift_val),
        .shift_idx (shift_idx),
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    logic [8:0] tbl [ROWS][SHIFTS];
    int         stall [ROWS];

    // Generator table: registered read, word valid the cycle after row_sel changes.
    always @(posedge clk) g_row <= {tbl[row_sel][0], tbl[row_sel][1], tbl[row_sel][2]};

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int idle_err, idle_row_known, idle_row, after_reset;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int load_of(input int row);
        int c = 1;
        for (int r = 0; r < row; r++) c += 5 + stall[r];
        return c;
    endfunction

    function automatic int hs_of(input int row);
        return load_of(row) + 1 + stall[row];
    endfunction

    function automatic int done_of();
        return hs_of(ROWS - 1) + 4;
    endfunction

    function automatic bit row_bad(input int r);
        bit b = 0;
        for (int k = 0; k < SHIFTS; k++) if (int'(tbl[r][k]) >= CIRC) b = 1;
        return b;
    endfunction

    task automatic check_idle();
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_acc_clr", acc_clr, 0);
        check("idle_msg_ready", msg_ready, 0);
        check("idle_acc_en", acc_en, 0);
        check("idle_err", err, idle_err);
        if (idle_row_known != 0) check("idle_row_sel", row_sel, idle_row);
        if (after_reset != 0) begin
            check("rst_shift_val", shift_val, 0);
            check("rst_shift_idx", shift_idx, 0);
        end
    endtask

    task automatic idle_cycle(input logic s, input logic a);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        start     = s;
        abort     = a;
        msg_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        cyc++;
        check_idle();
    endtask

    // kind 0: complete run; 1: abort in cycle stop_at; 2: reset in cycle stop_at.
    task automatic run(input int kind, input int stop_at, output int done_seen);
        int load_c [ROWS];
        int hs_c [ROWS];
        int done_c, last, ei;
        bit e_en, e_rdy, e_err;
        int e_val, e_row;
        for (int r = 0; r < ROWS; r++) begin
            load_c[r] = load_of(r);
            hs_c[r]   = hs_of(r);
        end
        done_c    = done_of();
        last      = (kind == 0) ? done_c : ((stop_at > done_c) ? done_c : stop_at);
        done_seen = -1;
        for (int t = 0; t <= last; t++) begin
            @(posedge clk);
            #1;
            rst_n     = !(kind == 2 && t == last);
            abort     = (kind == 1 && t == last);
            start     = (t == 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
            msg_valid = 1'($urandom_range(0, 1));
            for (int r = 0; r < ROWS; r++)
                if (t > load_c[r] && t <= hs_c[r]) msg_valid = (t == hs_c[r]);
            @(negedge clk);
            cyc++;
            if (t == 0) begin
                check_idle();
                after_reset = 0;
            end else begin
                e_en = 0; e_rdy = 0; e_err = 0; e_val = 0; e_row = 0; ei = 0;
                for (int r = 0; r < ROWS; r++) begin
                    if (t >= load_c[r]) e_row = r;
                    if (t > load_c[r] && t <= hs_c[r]) e_rdy = 1;
                    if (t > hs_c[r] && t <= hs_c[r] + 3) begin
                        e_en  = 1;
                        ei    = t - hs_c[r] - 1;
                        e_val = (int'(tbl[r][ei]) >= CIRC) ? 0 : int'(tbl[r][ei]);
                    end
                    if (row_bad(r) && hs_c[r] < t) e_err = 1;
                end
                check("busy", busy, int'(t < done_c));
                check("done", done, int'(t == done_c));
                check("acc_clr", acc_clr, int'(t == 1));
                check("msg_ready", msg_ready, e_rdy);
                check("acc_en", acc_en, e_en);
                check("err", err, e_err);
                check("row_sel", row_sel, e_row);
                if (e_en) begin
                    check("shift_val", shift_val, e_val);
                    check("shift_idx", shift_idx, ei);
                end
            end
            if (done === 1'b1) done_seen = t;
        end
        if (kind == 2) begin
            idle_err = 0; idle_row_known = 1; idle_row = 0; after_reset = 1;
        end else begin
            idle_err = 0;
            for (int r = 0; r < ROWS; r++) if (row_bad(r) && hs_c[r] < last) idle_err = 1;
            idle_row_known = (kind == 0);
            idle_row       = ROWS - 1;
            after_reset    = 0;
        end
    endtask

    task automatic random_table();
        for (int r = 0; r < ROWS; r++) begin
            for (int k = 0; k < SHIFTS; k++) tbl[r][k] = 9'($urandom_range(0, CIRC - 1));
            if ($urandom_range(0, 7) == 0) tbl[r][$urandom_range(0, SHIFTS - 1)] = 9'd511;
        end
    endtask

    initial begin
        int ds, kind;
        random_table();
        for (int r = 0; r < ROWS; r++) for (int k = 0; k < SHIFTS; k++)
            if (tbl[r][k] == 9'd511) tbl[r][k] = 9'd0;
        tbl[0][0]  = 9'd176; tbl[0][1]  = 9'd1;   tbl[0][2]  = 9'd499;
        tbl[7][0]  = 9'd472; tbl[7][1]  = 9'd511; tbl[7][2]  = 9'd458;
        tbl[15][0] = 9'd413; tbl[15][1] = 9'd2;   tbl[15][2] = 9'd399;
        for (int r = 0; r < ROWS; r++) stall[r] = 0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        idle_err = 0; idle_row_known = 1; idle_row = 0; after_reset = 1;
        idle_cycle(1'b0, 1'b0);
        idle_cycle(1'b0, 1'b1);

        // Row 3 stalled by 4 cycles.
        stall[3] = 4;
        run(0, 0, ds);
        check("done_cycle_stall", ds, 85);

        // Back-to-back start in the idle cycle right after done.
        stall[3] = 0;
        run(0, 0, ds);
        check("done_cycle_nominal", ds, 81);

        idle_cycle(1'b1, 1'b1);
        idle_cycle(1'b0, 1'b0);

        // Abort in row 5 at shift index 1, then restart immediately.
        run(1, hs_of(5) + 2, ds);
        check("no_done_on_abort", ds, -1);
        run(0, 0, ds);

        // Reset mid-run.
        run(2, 40, ds);
        idle_cycle(1'b0, 1'b0);
        idle_cycle(1'b0, 1'b1);

        for (int n = 0; n < 10; n++) begin
            random_table();
            for (int r = 0; r < ROWS; r++)
                stall[r] = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 3);
            kind = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            run(kind, $urandom_range(1, done_of()), ds);
            repeat ($urandom_range(0, 2)) idle_cycle(1'b0, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
